slot_reader: RTL
================

# slot_reader

Sequenced read-out engine for the paper processor's 4-entry slot bank. It holds four data words and, on a start pulse, streams them out using the processor's 2-bit counter/status address encoding: counter 0→slot 00, 1→slot 01, 2→slot 10, status→slot 11. It is the consumer end of that encoding. The address generator picks a slot; this block owns the bank, walks the counter, honours the status override and delivers words over a valid/ready handshake.

## Interface

- DATA_W, 8, width of each slot word and of wr_data/out_data
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write strobe for the slot bank
- wr_addr  input  2  slot written when wr_en=1
- wr_data  input  DATA_W  write data
- start  input  1  begin a burst; sampled only in IDLE
- status  input  1  status override; forces the next beat to slot 11 and ends the burst
- out_ready  input  1  downstream accepts the current beat
- out_valid  output  1  out_addr/out_data hold a beat
- out_addr  output  2  slot address of the current beat
- out_data  output  DATA_W  slot contents for the current beat
- busy  output  1  high in SEND
- done  output  1  one-cycle pulse after the final beat transfers

## Operation

- Slot bank: 4 × DATA_W registers.
  - A write on any cycle with wr_en=1 updates slot wr_addr at the clock edge.
  - Writes are legal in every state.
- Address map: addr = {(cnt==2)|st, (cnt==1)|st}. cnt is a 2-bit beat counter; st is the latched status flag.
- State machine: IDLE, SEND, DONE.
- IDLE:
  - If start=1, load beat 0: cnt←0, st←status, out_addr←map(0,status), out_data←slot[map], out_valid←1, and go to SEND.
  - If start=0, stay in IDLE.
- SEND: a beat transfers on any cycle with out_valid & out_ready.
  - While no transfer occurs, out_valid, out_addr and out_data hold stable.
  - On a transfer with st=1 or cnt==2, this was the final beat: out_valid←0 and go to DONE.
  - On any other transfer: cnt←cnt+1 and st←status (sampled on the transfer cycle), then load the next beat from map(cnt+1, status). out_valid stays 1.
  - status=1 while no transfer occurs has no effect.
- DONE: done=1 for exactly this cycle, then go to IDLE. start is ignored in DONE.
- start is ignored in SEND and DONE. Only one burst is active at a time, and start does not queue.
- Write/read collision: when a beat is loaded from slot S in the same cycle wr_en=1 with wr_addr=S, out_data takes wr_data (write-first forwarding).
  - Writes to the slot of a beat already presented do not change out_data.
- Burst lengths:
  - Normal burst: 3 beats (00, 01, 10). cnt never reaches 3.
  - Status at start: 1 beat (11).
  - Status at the k-th transfer (k=1,2): k+1 beats, the last being 11.

## Timing

- Reset is synchronous and takes priority over every other input. Next edge after reset=1:
  - state=IDLE, cnt=0, st=0
  - out_valid=0, out_addr=00, out_data=0, busy=0, done=0
  - all slots=0
- Reset mid-burst abandons the burst: no done pulse, out_valid=0 the next cycle.
- Start to first valid: start sampled at edge N gives out_valid=1 from after edge N (1-cycle latency).
- With out_ready held 1, beats transfer on consecutive cycles: 3 beats in 3 cycles.
- done pulses in the cycle after the final transfer. busy falls at that same edge.
- Earliest next start is in the cycle after done, so bursts are spaced at least 1 idle cycle apart.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- Write slots 0..3 = 0x11, 0x22, 0x33, 0x44; start, status=0, out_ready=1 → beats (00,0x11), (01,0x22), (10,0x33) on 3 consecutive cycles, then done=1 for 1 cycle, then IDLE.
- Same contents; start with status=1 → single beat (11,0x44), then done. Slots 00/01/10 are never presented.
- Normal burst with status=1 only on the first transfer cycle → beats (00,0x11), (11,0x44), then done.
- Backpressure: out_ready=0 for 4 cycles on beat 01 → (01,0x22) held stable for all 4 cycles. On out_ready=1 it transfers, then (10,0x33) follows.
  - Pulsing start or writing slot 1 during the stall changes nothing.
- Forwarding: slot 2 = 0x33; write slot 2 = 0xAB in the cycle beat 01 transfers → the next beat is (10,0xAB).
- reset=1 while beat 01 is pending → next cycle out_valid=0, busy=0, done=0, all slots read 0. A new start then yields beats with data 0x00.

Source files
------------

// File: rtl/slot_reader.sv
// Read-out engine for the 4-entry slot bank: streams slots 00/01/10 on a start
// pulse, with the status flag redirecting the next beat to slot 11 and ending the burst.
module slot_reader #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              status,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [1:0]        out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic              st;
  logic [DATA_W-1:0] bank [4];

  logic              xfer;
  logic              ld;
  logic [1:0]        ld_cnt;
  logic              ld_st;
  logic [1:0]        ld_addr;

  // Counter/status encoding: counter values 0..2 pick slots 00..10, status wins with 11.
  function automatic logic [1:0] slot_map(input logic [1:0] c, input logic s);
    return {(c == 2'd2) | s, (c == 2'd1) | s};
  endfunction

  // Write-first read: a same-cycle write to the slot being loaded is forwarded.
  function automatic logic [DATA_W-1:0] read_fwd(input logic [1:0] a);
    if (wr_en && (wr_addr == a))
      return wr_data;
    return bank[a];
  endfunction

  assign xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (xfer && (st || (cnt == 2'd2))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld     = 1'b0;
    ld_cnt = cnt;
    ld_st  = st;
    case (state)
      IDLE: begin
        if (start) begin
          ld     = 1'b1;
          ld_cnt = 2'd0;
          ld_st  = status;
        end
      end
      SEND: begin
        if (xfer && !(st || (cnt == 2'd2))) begin
          ld     = 1'b1;
          ld_cnt = cnt + 2'd1;
          ld_st  = status;
        end
      end
      default: ;
    endcase
    ld_addr = slot_map(ld_cnt, ld_st);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) bank[i] <= '0;
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end
  end

  // Beat register: everything presented downstream comes straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 2'd0;
      st        <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= 2'b00;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= (state_nxt == SEND);
      busy      <= (state_nxt == SEND);
      done      <= (state_nxt == DONE);
      if (ld) begin
        cnt      <= ld_cnt;
        st       <= ld_st;
        out_addr <= ld_addr;
        out_data <= read_fwd(ld_addr);
      end
    end
  end

endmodule
